md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Multi-cycle multiply/divide unit with its own sequencing FSM. It owns the HI/LO registers and sits in the EX stage beside the ALU. The decoder supplies an MD operation code plus an enable. The unit runs the operation over a fixed latency and drives busy so the hazard logic can stall later MD instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
MDEn  input  1  MD instruction valid in EX this cycle
MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
A  input  32  rs operand
B  input  32  rt operand
busy  output  1  operation in progress (registered)
start  output  1  combinational: MDEn & (MDOp<=3) & ~busy
HI  output  32  HI register (registered)
LO  output  32  LO register (registered)

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, state=IDLE, cnt=0, pending results=0. Reset mid-operation aborts; HI/LO end at 0.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge t:
  - Compute the result from A/B at edge t and latch it into pending hi/lo registers.
  - Load cnt with MULT_CYCLES-1 (mult/multu) or DIV_CYCLES-1 (div/divu).
  - Go to RUN; busy=1 from edge t.
- RUN: cnt decrements each edge. At the edge where cnt==0:
  - HI/LO take the pending values.
  - busy drops to 0; state goes to IDLE.
  - So busy is high for exactly N cycles and HI/LO are visible N edges after the start edge, with N = MULT_CYCLES or DIV_CYCLES.
- Operand capture at edge t: A/B may change after t without effect.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0) for div/divu: the FSM still runs DIV_CYCLES with busy=1, but HI/LO keep their old values.
- mthi/mtlo: in IDLE with MDEn=1, HI (or LO) takes A at the next edge. Single cycle; busy stays 0.
- Any MDEn while busy=1 (start, mthi, mtlo) is ignored, and start=0. The pipeline must stall instead:
  - stall = MD-class instruction in D & (busy | start).
  - busy is registered, so the hazard unit must OR in start.
- Reserved MDOp 6/7 and MDEn=0: no state change.
- HI/LO are read directly by mfhi/mflo in EX. While busy=1 they hold the previous result; the stall rule above prevents stale reads.
- No back-to-back overlap: a new start is accepted in the cycle immediately after busy falls, i.e. the first IDLE cycle.

Test Plan:
- Reset with MDEn=1, MDOp=0 held -> HI=LO=0, busy=0 while reset=1. After release: start=1, busy=1 one edge later.
- mult A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; at the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo; then div with B=0 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged afterwards.
- Start mult, then on cycle 2 of busy issue mtlo A=0xDEAD and a second mult -> both ignored, start=0. The final HI/LO equal the first mult only. A new mult issued the cycle busy falls is accepted.
- Assert reset asynchronously mid-div (cycle 4) -> busy, HI, LO go to 0 immediately without a clock edge; next start behaves normally.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit owning HI/LO: results land MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure: MD requests while busy are dropped, so the hazard unit must stall on busy|start.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MDEn,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        start,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, div_b, quo_u, rem_u, quo_s, rem_s;

   // Low 64 bits of the extended product are exact for both signednesses.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide through magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
   assign abs_a = A[31] ? (32'd0 - A) : A;
   assign abs_b = B[31] ? (32'd0 - B) : B;
   assign div_b = (MDOp == OP_DIV) ? abs_b : B;
   assign quo_u = (div_b == 32'd0) ? 32'd0 : (((MDOp == OP_DIV) ? abs_a : A) / div_b);
   assign rem_u = (div_b == 32'd0) ? 32'd0 : (((MDOp == OP_DIV) ? abs_a : A) % div_b);
   assign quo_s = (A[31] ^ B[31]) ? (32'd0 - quo_u) : quo_u;
   assign rem_s = A[31] ? (32'd0 - rem_u) : rem_u;

   assign busy  = (state_q == S_RUN);
   assign start = MDEn & ~MDOp[2] & ~busy;
   assign HI    = hi_q;
   assign LO    = lo_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               if (MDOp[1]) begin
                  cnt_d     = 4'(DIV_CYCLES - 1);
                  pend_wr_d = (B != 32'd0);
                  pend_hi_d = (MDOp == OP_DIV) ? rem_s : rem_u;
                  pend_lo_d = (MDOp == OP_DIV) ? quo_s : quo_u;
               end else begin
                  cnt_d     = 4'(MULT_CYCLES - 1);
                  pend_wr_d = 1'b1;
                  pend_hi_d = (MDOp == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                  pend_lo_d = (MDOp == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
               end
            end else if (MDEn && MDOp == OP_MTHI) begin
               hi_d = A;
            end else if (MDEn && MDOp == OP_MTLO) begin
               lo_d = A;
            end
         end
         default: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   // OP_MULTU is referenced only through the MDOp[1]/OP_MULT split above.
   logic unused_ok;
   assign unused_ok = (OP_MULTU == 3'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO queued at issue, compared when busy falls.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MDEn;
   logic [2:0]  MDOp;
   logic [31:0] A, B;
   logic        busy, start;
   logic [31:0] HI, LO;

   int tests = 0;
   int fails = 0;
   logic [63:0] sb[$];

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDEn(MDEn), .MDOp(MDOp), .A(A), .B(B),
      .busy(busy), .start(start), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at the following negedge with MDEn low.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_start, input string tag);
      MDEn = 1'b1; MDOp = op; A = a; B = b;
      #1;
      check({tag, " start"}, 32'(start), 32'(exp_start));
      @(negedge clk);
      MDEn = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   task automatic wait_done(input int n_exp, input int cyc0, input string tag);
      int cyc = cyc0;
      logic [63:0] exp;
      while (busy && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 32'(cyc), 32'(n_exp));
      if (sb.size() == 0) begin
         check({tag, " scoreboard_entry"}, 32'd0, 32'd1);
      end else begin
         exp = sb.pop_front();
         check({tag, " HI"}, HI, exp[63:32]);
         check({tag, " LO"}, LO, exp[31:0]);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n, input string tag);
      sb.push_back(exp);
      issue(op, a, b, 1'b1, tag);
      wait_done(n, 0, tag);
   endtask

   initial begin
      reset = 1'b1; MDEn = 1'b1; MDOp = 3'd0; A = 32'd0; B = 32'd0;
      repeat (3) @(negedge clk);
      check("rst HI", HI, 32'd0);
      check("rst LO", LO, 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      reset = 1'b0;
      sb.push_back(64'd0);
      issue(3'd0, 32'd0, 32'd0, 1'b1, "post_rst");
      check("post_rst busy", 32'(busy), 32'd1);
      wait_done(5, 0, "post_rst");

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, "mult");
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 5, "multu");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, "multu_max");
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, "div");
      run_op(3'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 10, "divu");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, "div_ovf");

      issue(3'd4, 32'h11, 32'd0, 1'b0, "mthi");
      check("mthi busy", 32'(busy), 32'd0);
      check("mthi HI", HI, 32'h11);
      issue(3'd5, 32'h22, 32'd0, 1'b0, "mtlo");
      check("mtlo LO", LO, 32'h22);
      issue(3'd6, 32'h99, 32'd0, 1'b0, "rsvd");
      check("rsvd busy", 32'(busy), 32'd0);
      check("rsvd HI", HI, 32'h11);
      check("rsvd LO", LO, 32'h22);
      run_op(3'd2, 32'd1234, 32'd0, 64'h0000_0011_0000_0022, 10, "div0");

      // Requests arriving while busy must be dropped.
      sb.push_back(64'h0000_0000_0000_0023);
      issue(3'd0, 32'd5, 32'd7, 1'b1, "m1");
      @(negedge clk);
      MDEn = 1'b1; MDOp = 3'd5; A = 32'hDEAD;
      #1 check("mtlo_busy start", 32'(start), 32'd0);
      @(negedge clk);
      MDOp = 3'd0; A = 32'd100; B = 32'd100;
      #1 check("mult_busy start", 32'(start), 32'd0);
      @(negedge clk);
      MDEn = 1'b0;
      wait_done(5, 3, "m1");
      run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5, "b2b");

      // Asynchronous reset mid-divide.
      sb.push_back(64'd0);
      issue(3'd3, 32'd100, 32'd7, 1'b1, "div_rst");
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("arst busy", 32'(busy), 32'd0);
      check("arst HI", HI, 32'd0);
      check("arst LO", LO, 32'd0);
      void'(sb.pop_front());
      #1 reset = 1'b0;
      @(negedge clk);
      run_op(3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
